// File: rtl/morse_pkg.sv
// morse_pkg: shared widths, FSM state type and letter patterns A-H for the Morse encoder.
package morse_pkg;
  localparam int PATTERN_W = 12;
  localparam int LEN_W = 4;
`ifdef MORSE_TRAILING_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  localparam logic [PATTERN_W-1:0] PAT_A = 12'b1011_1000_0000;
  localparam logic [PATTERN_W-1:0] PAT_B = 12'b1110_1010_1000;
  localparam logic [PATTERN_W-1:0] PAT_C = 12'b1110_1011_1010;
  localparam logic [PATTERN_W-1:0] PAT_D = 12'b1110_1010_0000;
  localparam logic [PATTERN_W-1:0] PAT_E = 12'b1000_0000_0000;
  localparam logic [PATTERN_W-1:0] PAT_F = 12'b1010_1110_1000;
  localparam logic [PATTERN_W-1:0] PAT_G = 12'b1110_1110_1000;
  localparam logic [PATTERN_W-1:0] PAT_H = 12'b1010_1010_0000;
  localparam logic [LEN_W-1:0] LEN_A = 4'd5;
  localparam logic [LEN_W-1:0] LEN_B = 4'd9;
  localparam logic [LEN_W-1:0] LEN_C = 4'd11;
  localparam logic [LEN_W-1:0] LEN_D = 4'd7;
  localparam logic [LEN_W-1:0] LEN_E = 4'd1;
  localparam logic [LEN_W-1:0] LEN_F = 4'd9;
  localparam logic [LEN_W-1:0] LEN_G = 4'd9;
  localparam logic [LEN_W-1:0] LEN_H = 4'd7;
endpackage

// File: rtl/morse_rom.sv
// morse_rom: letter select to left-aligned unit pattern and pattern length.
module morse_rom
  import morse_pkg::*;
(
  input  logic [2:0]           letter_i,
  output logic [PATTERN_W-1:0] pattern_o,
  output logic [LEN_W-1:0]     length_o
);
  always_comb begin
    pattern_o = '0;
    length_o = '0;
    case (letter_i)
      3'd0: begin pattern_o = PAT_A; length_o = LEN_A; end
      3'd1: begin pattern_o = PAT_B; length_o = LEN_B; end
      3'd2: begin pattern_o = PAT_C; length_o = LEN_C; end
      3'd3: begin pattern_o = PAT_D; length_o = LEN_D; end
      3'd4: begin pattern_o = PAT_E; length_o = LEN_E; end
      3'd5: begin pattern_o = PAT_F; length_o = LEN_F; end
      3'd6: begin pattern_o = PAT_G; length_o = LEN_G; end
      3'd7: begin pattern_o = PAT_H; length_o = LEN_H; end
    endcase
  end
endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: serialises letters A-H as Morse units on an LED, one unit per UNIT_TICKS ticks.
// Define MORSE_TRAILING_GAP_EN to append a 3-unit silent gap before Done.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int UNIT_TICKS = 1
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       MorseOut,
  output logic       Busy,
  output logic       Done
);
  localparam int CW = $clog2(UNIT_TICKS) + 1;
  localparam logic [CW-1:0] LAST = CW'(UNIT_TICKS - 1);
  state_t state_q, state_d;
  logic [PATTERN_W-1:0] shift_q, shift_d, rom_pat;
  logic [LEN_W-1:0] rem_q, rem_d, rom_len;
  logic [CW-1:0] unit_q, unit_d;
  logic done_q, done_d, unit_end;
  morse_rom u_rom (
    .letter_i (Letter),
    .pattern_o(rom_pat),
    .length_o (rom_len)
  );
  assign unit_end = Tick && unit_q == LAST;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d = rem_q;
    unit_d = unit_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (Start) begin
        state_d = SEND;
        shift_d = rom_pat;
        rem_d = rom_len;
        unit_d = '0;
      end
    end else begin
      if (Tick) unit_d = unit_end ? '0 : unit_q + 1'b1;
      if (unit_end) begin
        if (rem_q > LEN_W'(1)) begin
          rem_d = rem_q - 1'b1;
          shift_d = shift_q << 1;
        end else begin
`ifdef MORSE_TRAILING_GAP_EN
          // the gap reuses the remaining count as a 3-unit countdown
          if (state_q == SEND) begin
            state_d = GAP;
            rem_d = LEN_W'(3);
          end else begin
            state_d = IDLE;
            done_d = 1'b1;
          end
`else
          state_d = IDLE;
          done_d = 1'b1;
`endif
        end
      end
    end
  end
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      rem_q <= '0;
      unit_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      rem_q <= rem_d;
      unit_q <= unit_d;
      done_q <= done_d;
    end
  end
  assign MorseOut = state_q == SEND && shift_q[PATTERN_W-1];
  assign Busy = state_q != IDLE;
  assign Done = done_q;
endmodule
